// File: rtl/rv_constants_pkg.sv
// rv_constants: shared encodings for the RV32I multi-cycle controller.
//   - RV32I base opcodes
//   - controller state enum (ctrl_state_t)
//   - alu_op_type, next_pc_select and writeback-select encodings
//   - alu_select(): ALU operand/op selects for a given opcode, used
//     identically in EXECUTE, MEM and WRITEBACK so the ALU result stays
//     stable while the instruction is in flight.
package rv_constants;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_TRAP      = 3'd5
   } ctrl_state_t;

   localparam logic [1:0] ALU_OP_ADD    = 2'd0;
   localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
   localparam logic [1:0] ALU_OP_OP     = 2'd2;
   localparam logic [1:0] ALU_OP_OP_IMM = 2'd3;

   localparam logic [1:0] NPC_PLUS4  = 2'd0;
   localparam logic [1:0] NPC_PC_IMM = 2'd1;
   localparam logic [1:0] NPC_ALU    = 2'd2;

   localparam logic [2:0] WB_ALU  = 3'd0;
   localparam logic [2:0] WB_MEM  = 3'd1;
   localparam logic [2:0] WB_PC4  = 3'd2;
   localparam logic [2:0] WB_IMM  = 3'd3;

   typedef struct packed {
      logic       a_pc;
      logic       b_imm;
      logic [1:0] op;
   } alu_sel_t;

   function automatic alu_sel_t alu_select(input logic [6:0] opcode);
      alu_sel_t s;
      s = '{a_pc: 1'b0, b_imm: 1'b0, op: ALU_OP_ADD};
      case (opcode)
         OPC_OP:                s = '{a_pc: 1'b0, b_imm: 1'b0, op: ALU_OP_OP};
         OPC_OP_IMM:            s = '{a_pc: 1'b0, b_imm: 1'b1, op: ALU_OP_OP_IMM};
         OPC_LOAD, OPC_STORE:   s = '{a_pc: 1'b0, b_imm: 1'b1, op: ALU_OP_ADD};
         OPC_AUIPC, OPC_JAL:    s = '{a_pc: 1'b1, b_imm: 1'b1, op: ALU_OP_ADD};
         OPC_JALR:              s = '{a_pc: 1'b0, b_imm: 1'b1, op: ALU_OP_ADD};
         OPC_BRANCH:            s = '{a_pc: 1'b0, b_imm: 1'b0, op: ALU_OP_BRANCH};
         default:               s = '{a_pc: 1'b0, b_imm: 1'b0, op: ALU_OP_ADD};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/branch_condition.sv
// branch_condition: resolves a conditional branch from funct3 and the ALU
// zero flag. The ALU computes SUB for BEQ/BNE and SLT/SLTU for the ordered
// compares, so for those "zero" means "not less than".
//   funct3  in  3  branch funct3
//   zero    in  1  ALU result == 0
//   taken   out 1  branch is taken
//   illegal out 1  funct3 has no branch encoding (010, 011)
module branch_condition (
   input  logic [2:0] funct3,
   input  logic       zero,
   output logic       taken,
   output logic       illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         3'b000:         taken = zero;
         3'b001:         taken = !zero;
         3'b100, 3'b110: taken = !zero;
         3'b101, 3'b111: taken = zero;
         default:        illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle sequencing FSM.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   FETCH      | request instruction; latch IR when mem_ready
//   DECODE     | one idle cycle; legality check on opcode/funct3
//   EXECUTE    | ALU op; branches and fences retire here
//   MEM        | hold load/store request until mem_ready; stores retire
//   WRITEBACK  | write rd, update PC, retire
//   TRAP       | sticky halt, all enables low until reset
//
// Ports:
//   clock, reset (async active-high)
//   inst_opcode, inst_funct3       instruction register fields
//   alu_result_equal_zero          ALU zero flag (branch resolution)
//   mem_ready                      memory completes the current request
//   ir_write_enable, imem_read, dmem_read, dmem_write,
//   pc_write_enable, regfile_write_enable         enables/requests
//   alu_operand_a_select, alu_operand_b_select, alu_op_type,
//   next_pc_select, reg_writeback_select          datapath selects
//   trap                           sticky halt indicator
//   instret                        retired-instruction count (wraps)
module multicycle_control
   import rv_constants::*;
#(
   parameter int INSTRET_WIDTH  = 32,
   parameter bit TRAP_ON_SYSTEM = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [6:0]               inst_opcode,
   input  logic [2:0]               inst_funct3,
   input  logic                     alu_result_equal_zero,
   input  logic                     mem_ready,
   output logic                     ir_write_enable,
   output logic                     imem_read,
   output logic                     dmem_read,
   output logic                     dmem_write,
   output logic                     pc_write_enable,
   output logic                     regfile_write_enable,
   output logic                     alu_operand_a_select,
   output logic                     alu_operand_b_select,
   output logic [1:0]               alu_op_type,
   output logic [1:0]               next_pc_select,
   output logic [2:0]               reg_writeback_select,
   output logic                     trap,
   output logic [INSTRET_WIDTH-1:0] instret
);

   localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

   ctrl_state_t state;
   logic [INSTRET_WIDTH-1:0] instret_q;

   logic branch_taken;
   logic branch_illegal;
   logic opcode_legal;
   logic is_nop_opcode;
   alu_sel_t sel;

   // Enables before reset gating; pc_we_int doubles as the retire strobe
   // because every instruction updates the PC exactly once, when it retires.
   logic ir_we_int;
   logic imem_rd_int;
   logic dmem_rd_int;
   logic dmem_wr_int;
   logic pc_we_int;
   logic rf_we_int;

   branch_condition u_branch_condition (
      .funct3  (inst_funct3),
      .zero    (alu_result_equal_zero),
      .taken   (branch_taken),
      .illegal (branch_illegal)
   );

   assign sel = alu_select(inst_opcode);

   // MISC_MEM (fence) is always a NOP; SYSTEM only when it does not trap.
   assign is_nop_opcode = (inst_opcode == OPC_MISC_MEM) ||
                          (!TRAP_ON_SYSTEM && (inst_opcode == OPC_SYSTEM));

   always_comb begin
      opcode_legal = 1'b0;
      case (inst_opcode)
         OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR,
         OPC_LUI, OPC_AUIPC, OPC_MISC_MEM: opcode_legal = 1'b1;
         OPC_BRANCH:                       opcode_legal = !branch_illegal;
         OPC_SYSTEM:                       opcode_legal = !TRAP_ON_SYSTEM;
         default:                          opcode_legal = 1'b0;
      endcase
   end

   always_comb begin
      ir_we_int            = 1'b0;
      imem_rd_int          = 1'b0;
      dmem_rd_int          = 1'b0;
      dmem_wr_int          = 1'b0;
      pc_we_int            = 1'b0;
      rf_we_int            = 1'b0;
      alu_operand_a_select = 1'b0;
      alu_operand_b_select = 1'b0;
      alu_op_type          = ALU_OP_ADD;
      next_pc_select       = NPC_PLUS4;
      reg_writeback_select = WB_ALU;
      trap                 = 1'b0;

      unique case (state)
         ST_FETCH: begin
            imem_rd_int = 1'b1;
            ir_we_int   = mem_ready;
         end

         ST_DECODE: begin
         end

         ST_EXECUTE: begin
            alu_operand_a_select = sel.a_pc;
            alu_operand_b_select = sel.b_imm;
            alu_op_type          = sel.op;
            if (inst_opcode == OPC_BRANCH) begin
               pc_we_int      = 1'b1;
               next_pc_select = branch_taken ? NPC_PC_IMM : NPC_PLUS4;
            end else if (is_nop_opcode) begin
               pc_we_int = 1'b1;
            end
         end

         ST_MEM: begin
            alu_operand_a_select = sel.a_pc;
            alu_operand_b_select = sel.b_imm;
            alu_op_type          = sel.op;
            if (inst_opcode == OPC_STORE) begin
               dmem_wr_int = 1'b1;
               pc_we_int   = mem_ready;
            end else begin
               dmem_rd_int = 1'b1;
            end
         end

         ST_WRITEBACK: begin
            alu_operand_a_select = sel.a_pc;
            alu_operand_b_select = sel.b_imm;
            alu_op_type          = sel.op;
            rf_we_int            = 1'b1;
            pc_we_int            = 1'b1;
            case (inst_opcode)
               OPC_LOAD:          reg_writeback_select = WB_MEM;
               OPC_JAL, OPC_JALR: reg_writeback_select = WB_PC4;
               OPC_LUI:           reg_writeback_select = WB_IMM;
               default:           reg_writeback_select = WB_ALU;
            endcase
            case (inst_opcode)
               OPC_JAL:  next_pc_select = NPC_PC_IMM;
               OPC_JALR: next_pc_select = NPC_ALU;
               default:  next_pc_select = NPC_PLUS4;
            endcase
         end

         ST_TRAP: begin
            trap = 1'b1;
         end

         default: begin
         end
      endcase
   end

   // Gate enables with reset so an in-flight memory request drops the
   // moment reset asserts, not at the next edge.
   assign ir_write_enable      = ir_we_int   && !reset;
   assign imem_read            = imem_rd_int && !reset;
   assign dmem_read            = dmem_rd_int && !reset;
   assign dmem_write           = dmem_wr_int && !reset;
   assign pc_write_enable      = pc_we_int   && !reset;
   assign regfile_write_enable = rf_we_int   && !reset;
   assign instret              = instret_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_FETCH;
         instret_q <= '0;
      end else begin
         if (pc_we_int) begin
            instret_q <= instret_q + INSTRET_ONE;
         end
         unique case (state)
            ST_FETCH: begin
               if (mem_ready) begin
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state <= opcode_legal ? ST_EXECUTE : ST_TRAP;
            end
            ST_EXECUTE: begin
               if ((inst_opcode == OPC_BRANCH) || is_nop_opcode) begin
                  state <= ST_FETCH;
               end else if ((inst_opcode == OPC_LOAD) || (inst_opcode == OPC_STORE)) begin
                  state <= ST_MEM;
               end else begin
                  state <= ST_WRITEBACK;
               end
            end
            ST_MEM: begin
               if (mem_ready) begin
                  state <= (inst_opcode == OPC_STORE) ? ST_FETCH : ST_WRITEBACK;
               end
            end
            ST_WRITEBACK: begin
               state <= ST_FETCH;
            end
            ST_TRAP: begin
               state <= ST_TRAP;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam int IW = 4;

   logic          clock;
   logic          reset;
   logic [6:0]    inst_opcode;
   logic [2:0]    inst_funct3;
   logic          alu_result_equal_zero;
   logic          mem_ready;
   logic          ir_write_enable;
   logic          imem_read;
   logic          dmem_read;
   logic          dmem_write;
   logic          pc_write_enable;
   logic          regfile_write_enable;
   logic          alu_operand_a_select;
   logic          alu_operand_b_select;
   logic [1:0]    alu_op_type;
   logic [1:0]    next_pc_select;
   logic [2:0]    reg_writeback_select;
   logic          trap;
   logic [IW-1:0] instret;

   multicycle_control #(.INSTRET_WIDTH(IW), .TRAP_ON_SYSTEM(1'b1)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .inst_opcode           (inst_opcode),
      .inst_funct3           (inst_funct3),
      .alu_result_equal_zero (alu_result_equal_zero),
      .mem_ready             (mem_ready),
      .ir_write_enable       (ir_write_enable),
      .imem_read             (imem_read),
      .dmem_read             (dmem_read),
      .dmem_write            (dmem_write),
      .pc_write_enable       (pc_write_enable),
      .regfile_write_enable  (regfile_write_enable),
      .alu_operand_a_select  (alu_operand_a_select),
      .alu_operand_b_select  (alu_operand_b_select),
      .alu_op_type           (alu_op_type),
      .next_pc_select        (next_pc_select),
      .reg_writeback_select  (reg_writeback_select),
      .trap                  (trap),
      .instret               (instret)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {ir, imem, dr, dw, pcwe, rfwe, a, b, op[2], npc[2], wb[3], trap}
   logic [15:0] act;
   assign act = {ir_write_enable, imem_read, dmem_read, dmem_write, pc_write_enable,
                 regfile_write_enable, alu_operand_a_select, alu_operand_b_select,
                 alu_op_type, next_pc_select, reg_writeback_select, trap};

   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic       zero;
      int         fetch_wait;
      int         mem_wait;
      string      name;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   logic [IW-1:0] exp_instret = '0;
   int            cycles_seen;
   int            dread_waits;

   logic          stim_q[$];
   logic [15:0]   exp_q[$];

   function automatic logic [15:0] ev(input logic ir, input logic imem, input logic dr,
                                      input logic dw, input logic pcwe, input logic rfwe,
                                      input logic a, input logic b, input logic [1:0] op,
                                      input logic [1:0] npc, input logic [2:0] wb,
                                      input logic tr);
      return {ir, imem, dr, dw, pcwe, rfwe, a, b, op, npc, wb, tr};
   endfunction

   function automatic logic legal(input logic [6:0] opc, input logic [2:0] f3);
      case (opc)
         7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
         7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111: return 1'b1;
         7'b1100011: return !(f3 == 3'b010 || f3 == 3'b011);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic taken(input logic [2:0] f3, input logic z);
      case (f3)
         3'b000: return z;
         3'b001: return !z;
         3'b100, 3'b110: return !z;
         default: return z;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Builds the expected per-cycle output sequence for one instruction
   // straight from the instruction's path, then plays it against the DUT.
   task automatic run_vec(input vec_t v);
      logic a, b;
      logic [1:0] op;
      logic [2:0] wb;
      logic [1:0] npc;
      logic retires;
      logic is_ld, is_st;
      a = 1'b0; b = 1'b0; op = 2'd0; wb = 3'd0; npc = 2'd0;
      retires = 1'b0;
      is_ld = (v.opc == 7'b0000011);
      is_st = (v.opc == 7'b0100011);
      case (v.opc)
         7'b0110011: begin a = 0; b = 0; op = 2; end
         7'b0010011: begin a = 0; b = 1; op = 3; end
         7'b0000011, 7'b0100011: begin a = 0; b = 1; op = 0; end
         7'b0010111, 7'b1101111: begin a = 1; b = 1; op = 0; end
         7'b1100111: begin a = 0; b = 1; op = 0; end
         7'b1100011: begin a = 0; b = 0; op = 1; end
         default: ;
      endcase

      inst_opcode = v.opc;
      inst_funct3 = v.f3;
      alu_result_equal_zero = v.zero;

      for (int i = 0; i < v.fetch_wait; i++) begin
         stim_q.push_back(1'b0);
         exp_q.push_back(ev(0,1,0,0,0,0,0,0,2'd0,2'd0,3'd0,0));
      end
      stim_q.push_back(1'b1);
      exp_q.push_back(ev(1,1,0,0,0,0,0,0,2'd0,2'd0,3'd0,0));
      stim_q.push_back(1'b1);
      exp_q.push_back(ev(0,0,0,0,0,0,0,0,2'd0,2'd0,3'd0,0));

      if (!legal(v.opc, v.f3)) begin
         for (int i = 0; i < 3; i++) begin
            stim_q.push_back(1'b1);
            exp_q.push_back(ev(0,0,0,0,0,0,0,0,2'd0,2'd0,3'd0,1));
         end
      end else if (v.opc == 7'b1100011) begin
         stim_q.push_back(1'b1);
         exp_q.push_back(ev(0,0,0,0,1,0,a,b,op,{1'b0, taken(v.f3, v.zero)},3'd0,0));
         retires = 1'b1;
      end else if (v.opc == 7'b0001111) begin
         stim_q.push_back(1'b1);
         exp_q.push_back(ev(0,0,0,0,1,0,0,0,2'd0,2'd0,3'd0,0));
         retires = 1'b1;
      end else begin
         stim_q.push_back(1'b1);
         exp_q.push_back(ev(0,0,0,0,0,0,a,b,op,2'd0,3'd0,0));
         if (is_ld || is_st) begin
            for (int i = 0; i < v.mem_wait; i++) begin
               stim_q.push_back(1'b0);
               exp_q.push_back(ev(0,0,is_ld,is_st,0,0,a,b,op,2'd0,3'd0,0));
            end
            stim_q.push_back(1'b1);
            exp_q.push_back(ev(0,0,is_ld,is_st,is_st,0,a,b,op,2'd0,3'd0,0));
         end
         if (!is_st) begin
            case (v.opc)
               7'b0000011: wb = 3'd1;
               7'b1101111, 7'b1100111: wb = 3'd2;
               7'b0110111: wb = 3'd3;
               default: wb = 3'd0;
            endcase
            case (v.opc)
               7'b1101111: npc = 2'd1;
               7'b1100111: npc = 2'd2;
               default: npc = 2'd0;
            endcase
            stim_q.push_back(1'b1);
            exp_q.push_back(ev(0,0,0,0,1,1,a,b,op,npc,wb,0));
         end
         retires = 1'b1;
      end

      cycles_seen = 0;
      dread_waits = 0;
      while (exp_q.size() > 0) begin
         logic [15:0] e;
         mem_ready = stim_q.pop_front();
         @(negedge clock);
         e = exp_q.pop_front();
         cycles_seen++;
         if (dmem_read && !mem_ready) dread_waits++;
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s cycle %0d outputs got=%b exp=%b", v.name, cycles_seen, act, e);
         end
         @(posedge clock);
         #1;
      end
      if (retires) exp_instret = exp_instret + 1'b1;
      check({v.name, " instret"}, 32'(instret), 32'(exp_instret));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_instret = '0;
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back('{7'b0010011, 3'b000, 1'b0, 0, 0, "addi"});
      tbl.push_back('{7'b0000011, 3'b010, 1'b0, 2, 3, "lw_wait"});
      tbl.push_back('{7'b0100011, 3'b010, 1'b0, 0, 0, "sw"});
      tbl.push_back('{7'b1100011, 3'b000, 1'b1, 0, 0, "beq_z1"});
      tbl.push_back('{7'b1100011, 3'b001, 1'b1, 0, 0, "bne_z1"});
      tbl.push_back('{7'b1100011, 3'b110, 1'b0, 0, 0, "bltu_z0"});
      tbl.push_back('{7'b1100011, 3'b101, 1'b1, 1, 0, "bge_z1"});
      tbl.push_back('{7'b1100111, 3'b000, 1'b0, 0, 0, "jalr"});
      tbl.push_back('{7'b1101111, 3'b000, 1'b0, 0, 0, "jal"});
      tbl.push_back('{7'b0110111, 3'b000, 1'b0, 0, 0, "lui"});
      tbl.push_back('{7'b0010111, 3'b000, 1'b0, 0, 0, "auipc"});
      tbl.push_back('{7'b0110011, 3'b000, 1'b0, 0, 0, "add"});
      tbl.push_back('{7'b0001111, 3'b000, 1'b0, 0, 0, "fence"});
      tbl.push_back('{7'b0100011, 3'b000, 1'b0, 1, 2, "sb_wait"});
      tbl.push_back('{7'b0000011, 3'b000, 1'b0, 0, 0, "lb"});

      reset = 1'b1;
      mem_ready = 1'b1;
      inst_opcode = 7'b0010011;
      inst_funct3 = 3'b000;
      alu_result_equal_zero = 1'b0;
      @(negedge clock);
      check("reset_outputs", 32'(act), 32'h0);
      check("reset_instret", 32'(instret), 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      foreach (tbl[i]) begin
         run_vec(tbl[i]);
         if (tbl[i].name == "lw_wait") begin
            check("lw_total_cycles", 32'(cycles_seen), 32'd10);
            check("lw_dmem_read_waits", 32'(dread_waits), 32'd3);
         end
         if (tbl[i].name == "addi") check("addi_cycles", 32'(cycles_seen), 32'd4);
      end

      // Illegal encodings trap and hold; instret must not move.
      run_vec('{7'b1111111, 3'b000, 1'b0, 0, 0, "illegal_opc"});
      do_reset();
      run_vec('{7'b0010011, 3'b000, 1'b0, 0, 0, "addi_after_trap"});
      run_vec('{7'b1100011, 3'b010, 1'b1, 0, 0, "branch_f3_010"});
      do_reset();
      run_vec('{7'b0110011, 3'b000, 1'b0, 0, 0, "add_pre_sys"});
      run_vec('{7'b1110011, 3'b000, 1'b0, 0, 0, "system_trap"});
      do_reset();

      // Reset in the middle of a store request.
      run_vec('{7'b0110011, 3'b000, 1'b0, 0, 0, "add_pre_rst"});
      inst_opcode = 7'b0100011;
      mem_ready = 1'b1;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      mem_ready = 1'b0;
      @(negedge clock);
      check("mid_mem_dmem_write", 32'(dmem_write), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_drops_dmem_write", 32'(dmem_write), 32'd0);
      check("rst_clears_instret", 32'(instret), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_instret = '0;
      @(negedge clock);
      check("rst_state_fetch", 32'(imem_read), 32'd1);
      @(posedge clock);
      #1;
      exp_instret = '0;
      mem_ready = 1'b1;
      // Re-sync: the DUT is in FETCH and mem_ready was 0 at the last edge.
      // Drive the wrap sequence from here.
      for (int i = 0; i < (1 << IW) - 1; i++) begin
         run_vec('{7'b0010011, 3'b000, 1'b0, 0, 0, "addi_fill"});
      end
      check("instret_all_ones", 32'(instret), 32'((1 << IW) - 1));
      run_vec('{7'b0010011, 3'b000, 1'b0, 0, 0, "addi_wrap"});
      check("instret_wrap_zero", 32'(instret), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
